splitter_with_flow_control: RTL and testbench

SPLITTER_WITH_FLOW_CONTROL -- requirements
Module: splitter_with_flow_control

---
 rtl/splitter_with_flow_control.sv | 155 +++++++++++++++
 tb/tb_splitter_with_flow_control.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/splitter_with_flow_control.sv
// Splits each upstream word S into a floor half (a) and a saturated ceiling
// half (b). The datapath is a 2-entry input buffer, then an eager fork, then
// one 2-entry output buffer per branch. Every ready/valid is derived from
// registered occupancy, so there is no combinational ready path through the
// block.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   sum_vld/sum_rdy/sum_data upstream word, width+1 bits
//   a_vld/a_rdy/a_data       floor half, S >> 1
//   b_vld/b_rdy/b_data       ceiling half, S - (S >> 1), saturated to all-ones
module splitter_with_flow_control #(
   parameter int unsigned width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sum_vld,
   output logic             sum_rdy,
   input  logic [width:0]   sum_data,
   output logic             a_vld,
   input  logic             a_rdy,
   output logic [width-1:0] a_data,
   output logic             b_vld,
   input  logic             b_rdy,
   output logic [width-1:0] b_data
);

   localparam int unsigned SW    = width + 1;
   localparam logic [1:0]  FULL  = 2'd2;
   localparam logic [1:0]  EMPTY = 2'd0;

   // Input buffer state
   logic [SW-1:0] in_mem_q [2];
   logic [SW-1:0] in_mem_d [2];
   logic          in_wr_q, in_wr_d, in_rd_q, in_rd_d;
   logic [1:0]    in_cnt_q, in_cnt_d;

   // Output buffer state, branch a
   logic [width-1:0] a_mem_q [2];
   logic [width-1:0] a_mem_d [2];
   logic             a_wr_q, a_wr_d, a_rd_q, a_rd_d;
   logic [1:0]       a_cnt_q, a_cnt_d;

   // Output buffer state, branch b
   logic [width-1:0] b_mem_q [2];
   logic [width-1:0] b_mem_d [2];
   logic             b_wr_q, b_wr_d, b_rd_q, b_rd_d;
   logic [1:0]       b_cnt_q, b_cnt_d;

   // Fork bookkeeping: a branch that already took the head is not offered it again
   logic sent_a_q, sent_a_d, sent_b_q, sent_b_d;

   logic             in_push, in_pop, head_vld;
   logic [SW-1:0]    head;
   logic [width-1:0] split_a, split_b;
   logic             acc_a, acc_b, a_pop, b_pop;

   // Handshake terms, all from registered occupancy
   assign sum_rdy  = (in_cnt_q != FULL);
   assign in_push  = sum_vld & sum_rdy;
   assign head_vld = (in_cnt_q != EMPTY);
   assign head     = in_mem_q[in_rd_q];

   assign a_vld  = (a_cnt_q != EMPTY);
   assign b_vld  = (b_cnt_q != EMPTY);
   assign a_data = a_mem_q[a_rd_q];
   assign b_data = b_mem_q[b_rd_q];
   assign a_pop  = a_vld & a_rdy;
   assign b_pop  = b_vld & b_rdy;

   // Split arithmetic; only the all-ones input has a ceiling half that overflows
   assign split_a = width'(head >> 1);
   assign split_b = (head == {SW{1'b1}}) ? {width{1'b1}}
                                         : width'(head - (head >> 1));

   // Eager fork: each branch takes the head independently; head pops once both have it
   assign acc_a  = head_vld & ~sent_a_q & (a_cnt_q != FULL);
   assign acc_b  = head_vld & ~sent_b_q & (b_cnt_q != FULL);
   assign in_pop = head_vld & (sent_a_q | acc_a) & (sent_b_q | acc_b);

   always_comb begin
      sent_a_d = sent_a_q;
      sent_b_d = sent_b_q;
      if (in_pop) begin
         sent_a_d = 1'b0;
         sent_b_d = 1'b0;
      end else begin
         if (acc_a) sent_a_d = 1'b1;
         if (acc_b) sent_b_d = 1'b1;
      end
   end

   // Input buffer next state
   always_comb begin
      in_mem_d = in_mem_q;
      if (in_push) in_mem_d[in_wr_q] = sum_data;
      in_wr_d  = in_wr_q ^ in_push;
      in_rd_d  = in_rd_q ^ in_pop;
      in_cnt_d = in_cnt_q + 2'(in_push) - 2'(in_pop);
   end

   // Branch a buffer next state
   always_comb begin
      a_mem_d = a_mem_q;
      if (acc_a) a_mem_d[a_wr_q] = split_a;
      a_wr_d  = a_wr_q ^ acc_a;
      a_rd_d  = a_rd_q ^ a_pop;
      a_cnt_d = a_cnt_q + 2'(acc_a) - 2'(a_pop);
   end

   // Branch b buffer next state
   always_comb begin
      b_mem_d = b_mem_q;
      if (acc_b) b_mem_d[b_wr_q] = split_b;
      b_wr_d  = b_wr_q ^ acc_b;
      b_rd_d  = b_rd_q ^ b_pop;
      b_cnt_d = b_cnt_q + 2'(acc_b) - 2'(b_pop);
   end

   // State registers; reset empties every buffer and zeroes held data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_mem_q <= '{default: '0};
         in_wr_q  <= 1'b0;
         in_rd_q  <= 1'b0;
         in_cnt_q <= EMPTY;
         a_mem_q  <= '{default: '0};
         a_wr_q   <= 1'b0;
         a_rd_q   <= 1'b0;
         a_cnt_q  <= EMPTY;
         b_mem_q  <= '{default: '0};
         b_wr_q   <= 1'b0;
         b_rd_q   <= 1'b0;
         b_cnt_q  <= EMPTY;
         sent_a_q <= 1'b0;
         sent_b_q <= 1'b0;
      end else begin
         in_mem_q <= in_mem_d;
         in_wr_q  <= in_wr_d;
         in_rd_q  <= in_rd_d;
         in_cnt_q <= in_cnt_d;
         a_mem_q  <= a_mem_d;
         a_wr_q   <= a_wr_d;
         a_rd_q   <= a_rd_d;
         a_cnt_q  <= a_cnt_d;
         b_mem_q  <= b_mem_d;
         b_wr_q   <= b_wr_d;
         b_rd_q   <= b_rd_d;
         b_cnt_q  <= b_cnt_d;
         sent_a_q <= sent_a_d;
         sent_b_q <= sent_b_d;
      end
   end

endmodule

// File: tb/tb_splitter_with_flow_control.sv
// Bench for splitter_with_flow_control: table of single-word splits, directed
// multi-cycle sequences, and a randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_splitter_with_flow_control;

   localparam int unsigned W  = 8;
   localparam int unsigned SW = W + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          sum_vld, sum_rdy;
   logic [SW-1:0] sum_data;
   logic          a_vld, a_rdy, b_vld, b_rdy;
   logic [W-1:0]  a_data, b_data;

   always #5 clk = ~clk;

   splitter_with_flow_control #(.width(W)) dut (
      .clk(clk), .rst(rst),
      .sum_vld(sum_vld), .sum_rdy(sum_rdy), .sum_data(sum_data),
      .a_vld(a_vld), .a_rdy(a_rdy), .a_data(a_data),
      .b_vld(b_vld), .b_rdy(b_rdy), .b_data(b_data)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_in = 0, n_a = 0, n_b = 0;
   int q_a[$];
   int q_b[$];
   bit pa_hold = 0, pb_hold = 0;
   logic [W-1:0] pa_data, pb_data;
   int s_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Reference split: floor half and ceiling half clamped to the output range
   function automatic int ref_a(input int s);
      return s / 2;
   endfunction

   function automatic int ref_b(input int s);
      int h;
      h = s - s / 2;
      if (h > (1 << W) - 1) h = (1 << W) - 1;
      return h;
   endfunction

   // Scoreboard: at each falling edge, record the transfers the next rising edge will make
   always @(negedge clk) begin
      if (!rst) begin
         q_a.delete();
         q_b.delete();
         pa_hold = 0;
         pb_hold = 0;
      end else begin
         if (pa_hold) begin
            check("a_hold_vld", 32'(a_vld), 32'd1);
            check("a_hold_data", 32'(a_data), 32'(pa_data));
         end
         if (pb_hold) begin
            check("b_hold_vld", 32'(b_vld), 32'd1);
            check("b_hold_data", 32'(b_data), 32'(pb_data));
         end
         if (sum_vld && sum_rdy) begin
            s_m = int'(sum_data);
            q_a.push_back(ref_a(s_m));
            q_b.push_back(ref_b(s_m));
            n_in++;
         end
         if (a_vld && a_rdy) begin
            check("a_expected_word", 32'(q_a.size() > 0), 32'd1);
            if (q_a.size() > 0) check("a_data", 32'(a_data), 32'(q_a.pop_front()));
            n_a++;
         end
         if (b_vld && b_rdy) begin
            check("b_expected_word", 32'(q_b.size() > 0), 32'd1);
            if (q_b.size() > 0) check("b_data", 32'(b_data), 32'(q_b.pop_front()));
            n_b++;
         end
         pa_hold = a_vld && !a_rdy;
         pb_hold = b_vld && !b_rdy;
         pa_data = a_data;
         pb_data = b_data;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, got no end of test, want end of test");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One word through an empty path: vld low after edge t, high for exactly one cycle after t+1
   task automatic single_word(input logic [SW-1:0] s, input logic [W-1:0] ea,
                              input logic [W-1:0] eb, input string tag);
      a_rdy = 1'b1;
      b_rdy = 1'b1;
      sum_vld = 1'b1;
      sum_data = s;
      @(negedge clk);
      check({tag, "_sum_rdy"}, 32'(sum_rdy), 32'd1);
      @(posedge clk);
      #1;
      sum_vld = 1'b0;
      @(negedge clk);
      check({tag, "_vld_t1"}, 32'({a_vld, b_vld}), 32'd0);
      @(negedge clk);
      check({tag, "_vld_t2"}, 32'({a_vld, b_vld}), 32'd3);
      check({tag, "_a_data"}, 32'(a_data), 32'(ea));
      check({tag, "_b_data"}, 32'(b_data), 32'(eb));
      @(negedge clk);
      check({tag, "_vld_t3"}, 32'({a_vld, b_vld}), 32'd0);
      step();
   endtask

   typedef struct {
      logic [SW-1:0] s;
      logic [W-1:0]  ea;
      logic [W-1:0]  eb;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int i0, a0, b0, bubbles, rdy_drops, cyc;

      vecs[0] = '{s: 9'd37,  ea: 8'd18,  eb: 8'd19};
      vecs[1] = '{s: 9'd0,   ea: 8'd0,   eb: 8'd0};
      vecs[2] = '{s: 9'd510, ea: 8'd255, eb: 8'd255};
      vecs[3] = '{s: 9'd511, ea: 8'd255, eb: 8'd255};
      vecs[4] = '{s: 9'd1,   ea: 8'd0,   eb: 8'd1};
      vecs[5] = '{s: 9'd255, ea: 8'd127, eb: 8'd128};
      vecs[6] = '{s: 9'd2,   ea: 8'd1,   eb: 8'd1};
      vecs[7] = '{s: 9'd300, ea: 8'd150, eb: 8'd150};

      // Reset state, with upstream offering a word that must be ignored
      rst = 1'b0;
      sum_vld = 1'b1;
      sum_data = 9'd77;
      a_rdy = 1'b1;
      b_rdy = 1'b1;
      #3;
      check("rst_sum_rdy", 32'(sum_rdy), 32'd1);
      check("rst_vld", 32'({a_vld, b_vld}), 32'd0);
      check("rst_a_data", 32'(a_data), 32'd0);
      check("rst_b_data", 32'(b_data), 32'd0);
      step();
      step();
      step();
      check("rst_ignores_input", 32'({a_vld, b_vld, sum_rdy}), 32'd1);
      sum_vld = 1'b0;
      rst = 1'b1;

      // Table of single words, first one at the first edge out of reset
      for (int k = 0; k < 8; k++)
         single_word(vecs[k].s, vecs[k].ea, vecs[k].eb, $sformatf("vec%0d", k));

      // Back-to-back stream 0..20 with both consumers ready
      a0 = n_a;
      bubbles = 0;
      rdy_drops = 0;
      for (int i = 0; i <= 20; i++) begin
         sum_vld = 1'b1;
         sum_data = SW'(i);
         @(negedge clk);
         if (!sum_rdy) rdy_drops++;
         if (i >= 2 && !(a_vld && b_vld)) bubbles++;
         step();
      end
      sum_vld = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (!(a_vld && b_vld)) bubbles++;
      end
      @(negedge clk);
      check("b2b_drained", 32'({a_vld, b_vld}), 32'd0);
      check("b2b_bubbles", 32'(bubbles), 32'd0);
      check("b2b_rdy_drops", 32'(rdy_drops), 32'd0);
      check("b2b_count", 32'(n_a - a0), 32'd21);
      step();

      // Both consumers stalled: exactly four words held before sum_rdy drops
      i0 = n_in; a0 = n_a; b0 = n_b;
      a_rdy = 1'b0;
      b_rdy = 1'b0;
      sum_vld = 1'b1;
      repeat (6) begin
         sum_data = SW'($urandom);
         step();
      end
      check("full_words_held", 32'(n_in - i0), 32'd4);
      check("full_sum_rdy", 32'(sum_rdy), 32'd0);
      check("full_vld", 32'({a_vld, b_vld}), 32'd3);
      sum_vld = 1'b0;
      a_rdy = 1'b1;
      b_rdy = 1'b1;
      repeat (8) step();
      check("full_a_drained", 32'(n_a - a0), 32'd4);
      check("full_b_drained", 32'(n_b - b0), 32'd4);

      // Skewed stall: b blocked, a runs ahead only by the buffered words plus the forked head
      i0 = n_in; a0 = n_a; b0 = n_b;
      a_rdy = 1'b1;
      b_rdy = 1'b0;
      sum_vld = 1'b1;
      repeat (10) begin
         sum_data = SW'(n_in * 3);
         step();
      end
      check("skew_in", 32'(n_in - i0), 32'd4);
      check("skew_a", 32'(n_a - a0), 32'd3);
      check("skew_b", 32'(n_b - b0), 32'd0);
      check("skew_sum_rdy", 32'(sum_rdy), 32'd0);
      sum_vld = 1'b0;
      b_rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("skew_rdy_before_free", 32'(sum_rdy), 32'd0);
      @(negedge clk);
      check("skew_rdy_after_free", 32'(sum_rdy), 32'd1);
      step();
      repeat (8) step();
      check("skew_a_total", 32'(n_a - a0), 32'd4);
      check("skew_b_total", 32'(n_b - b0), 32'd4);
      check("skew_idle", 32'({a_vld, b_vld}), 32'd0);

      // Reset with three words held
      i0 = n_in;
      a_rdy = 1'b0;
      b_rdy = 1'b0;
      sum_vld = 1'b1;
      for (int k = 0; k < 10 && (n_in - i0) < 3; k++) begin
         sum_data = SW'(200 + k);
         step();
      end
      sum_vld = 1'b0;
      check("mid_held", 32'(n_in - i0), 32'd3);
      step();
      check("mid_vld_before_rst", 32'({a_vld, b_vld}), 32'd3);
      rst = 1'b0;
      #1;
      check("mid_rst_vld", 32'({a_vld, b_vld}), 32'd0);
      check("mid_rst_data", 32'({a_data, b_data}), 32'd0);
      check("mid_rst_sum_rdy", 32'(sum_rdy), 32'd1);
      sum_vld = 1'b1;
      sum_data = 9'd100;
      a_rdy = 1'b1;
      b_rdy = 1'b1;
      repeat (3) step();
      check("mid_in_rst_vld", 32'({a_vld, b_vld}), 32'd0);
      rst = 1'b1;
      single_word(9'd100, 8'd50, 8'd50, "post_rst");

      // Randomized traffic against the scoreboard
      i0 = n_in; a0 = n_a; b0 = n_b;
      cyc = 0;
      while (cyc < 60000 && (n_in - i0) < 10000) begin
         int r;
         r = int'($urandom_range(0, 7));
         sum_vld = 1'($urandom_range(0, 1));
         sum_data = (r == 0) ? 9'd511 : (r == 1) ? 9'd510 : (r == 2) ? 9'd0 : SW'($urandom);
         a_rdy = 1'($urandom_range(0, 1));
         b_rdy = 1'($urandom_range(0, 1));
         step();
         cyc++;
      end
      sum_vld = 1'b0;
      check("rand_words_in_budget", 32'((n_in - i0) >= 10000), 32'd1);
      a_rdy = 1'b1;
      b_rdy = 1'b1;
      repeat (10) step();
      check("rand_a_all", 32'(n_a - a0), 32'(n_in - i0));
      check("rand_b_all", 32'(n_b - b0), 32'(n_in - i0));
      check("rand_q_a_empty", 32'(q_a.size()), 32'd0);
      check("rand_q_b_empty", 32'(q_b.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
